seg7_scan_ctrl: RTL and testbench

//   Time-multiplexes NUM_DIGITS 4-bit hex values onto one shared hex-to-7-segment decoder
//   and a common segment bus. Each digit is enabled in turn through its active-low anode.
//   A dead-time blank between slots prevents ghosting.
//   New display data is double-buffered and takes effect only at a frame boundary, so the

---
 rtl/seg7_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed hex display driver: scans NUM_DIGITS nibbles onto one active-low 7-segment bus.
// Optional SEG7_LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 4,
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int CNT_W = $clog2(REFRESH_DIV)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   output logic                    ready,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    frame_tick
);

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } slot_state_e;

   slot_state_e               state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   active_q, active_d;
   logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
   logic                      pending_valid_q, pending_valid_d;
   logic [NUM_DIGITS-1:0]     an_q, an_d;
   logic [6:0]                seg_q, seg_d;
   logic                      slot_end;
   logic                      wrap;
   logic [3:0]                cur_nib;
   logic [NUM_DIGITS-1:0]     lz_mask;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign slot_end = (cnt_q == CNT_MAX);
   assign wrap     = slot_end && (idx_q == IDX_MAX);
   assign cur_nib  = active_q[4*idx_q +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // Digit i is a leading zero when it and every more-significant digit are zero.
   always_comb begin
      logic all_zero;
      lz_mask  = '0;
      all_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         all_zero   = all_zero && (active_q[4*i +: 4] == 4'h0);
         lz_mask[i] = all_zero && (i != 0);
      end
   end
`else
   assign lz_mask = '0;
`endif

   // Slot timing plus double-buffered data; pending only moves to active on a frame wrap.
   always_comb begin
      cnt_d           = cnt_q + CNT_W'(1);
      idx_d           = idx_q;
      active_d        = active_q;
      pending_d       = pending_q;
      pending_valid_d = pending_valid_q;
      if (slot_end) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end
      if (wrap && pending_valid_q) begin
         active_d        = pending_q;
         pending_valid_d = 1'b0;
      end
      if (load && !pending_valid_q) begin
         pending_d       = data_in;
         pending_valid_d = 1'b1;
      end
   end

   always_comb begin
      state_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_SHOW;
      an_d    = '1;
      seg_d   = 7'b1111111;
      if (state_q == ST_SHOW && !lz_mask[idx_q]) begin
         an_d[idx_q] = 1'b0;
         seg_d       = hex_to_seg(cur_nib);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_BLANK;
         cnt_q           <= '0;
         idx_q           <= '0;
         active_q        <= '0;
         pending_q       <= '0;
         pending_valid_q <= 1'b0;
         an_q            <= '1;
         seg_q           <= 7'b1111111;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         idx_q           <= idx_d;
         active_q        <= active_d;
         pending_q       <= pending_d;
         pending_valid_q <= pending_valid_d;
         an_q            <= an_d;
         seg_q           <= seg_d;
      end
   end

   assign ready      = !pending_valid_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign digit_idx  = idx_q;
   assign frame_tick = wrap;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-time model derived from elapsed cycles plus directed literal checks.
module tb_seg7_scan_ctrl;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int BC = 2;

   logic          clk;
   logic          rst;
   logic          load;
   logic [15:0]   data_in;
   logic          ready;
   logic [3:0]    an;
   logic [6:0]    seg;
   logic [1:0]    digit_idx;
   logic          frame_tick;

   int            checks = 0;
   int            failures = 0;
   int            t = 0;
   int            tick_total = 0;
   int            ticks0;
   logic          chk_en = 1'b0;
   logic [15:0]   m_active = '0;
   logic [15:0]   m_pending = '0;
   logic          m_valid = 1'b0;
   logic [3:0]    exp_an = 4'hF;
   logic [6:0]    exp_seg = 7'h7F;

   logic [6:0] seg_tab [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   seg7_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .data_in    (data_in),
      .ready      (ready),
      .an         (an),
      .seg        (seg),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
      end
   endtask

   function automatic logic suppressed(input int d, input logic [15:0] act);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      return (d > 0) && ((act >> (4*d)) == 16'h0);
`else
      return 1'b0 && (d > 0) && (act == act);
`endif
   endfunction

   // Model: t counts cycles since reset release; slot position is plain division of t.
   always @(posedge clk) begin : model
      int c;
      int d;
      logic acc;
      if (rst) begin
         t        = 0;
         m_active = '0;
         m_valid  = 1'b0;
         exp_an   = 4'hF;
         exp_seg  = 7'h7F;
      end else begin
         c       = t % RD;
         d       = (t / RD) % ND;
         exp_an  = 4'hF;
         exp_seg = 7'h7F;
         if (c >= BC && !suppressed(d, m_active)) begin
            exp_an[d] = 1'b0;
            exp_seg   = seg_tab[m_active[4*d +: 4]];
         end
         acc = load && !m_valid;
         if (c == RD-1 && d == ND-1 && m_valid) begin
            m_active = m_pending;
            m_valid  = 1'b0;
         end
         if (acc) begin
            m_pending = data_in;
            m_valid   = 1'b1;
         end
         t++;
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("an", 32'(an), 32'(exp_an));
            check("seg", 32'(seg), 32'(exp_seg));
            check("ready", 32'(ready), 32'(!m_valid));
            check("digit_idx", 32'(digit_idx), 32'((t / RD) % ND));
            check("frame_tick", 32'(frame_tick), 32'((t % RD == RD-1) && ((t / RD) % ND == ND-1)));
            check("an_one_low_max", 32'($countones(~an) <= 1), 32'd1);
            if (frame_tick) tick_total++;
         end
      end
   end

   task automatic wait_t(input int target);
      int n;
      n = 0;
      while (t != target && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (t != target) begin
         checks++;
         failures++;
         $display("FAIL wait_t: got t=%0d expected t=%0d", t, target);
      end
   endtask

   task automatic check_disp(input string name, input logic [3:0] e_an, input logic [6:0] e_seg);
      check({name, "_an"}, 32'(an), 32'(e_an));
      check({name, "_seg"}, 32'(seg), 32'(e_seg));
   endtask

   initial begin : directed
      rst     = 1'b1;
      load    = 1'b0;
      data_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_disp("reset", 4'b1111, 7'b1111111);
      check("reset_ready", 32'(ready), 32'd1);
      check("reset_idx", 32'(digit_idx), 32'd0);
      check("reset_tick", 32'(frame_tick), 32'd0);
      chk_en = 1'b1;
      rst    = 1'b0;

      for (int i = 1; i <= 4; i++) begin
         wait_t(8 * i);
         check("idx_step", 32'(digit_idx), 32'(i % 4));
      end

      load = 1'b1; data_in = 16'h1A8F;
      @(negedge clk);
      load = 1'b0;
      check("ready_after_load", 32'(ready), 32'd0);
      ticks0 = tick_total;
      wait_t(64);
      check("one_tick_per_frame", 32'(tick_total - ticks0), 32'd1);
      check("ready_after_wrap", 32'(ready), 32'd1);
      wait_t(67);
      check_disp("d0_F", 4'b1110, 7'b0001110);
      wait_t(91);
      check_disp("d3_1", 4'b0111, 7'b1111001);

      load = 1'b1; data_in = 16'h1234;
      @(negedge clk);
      check("ready_busy", 32'(ready), 32'd0);
      data_in = 16'hFFFF;
      @(negedge clk);
      load = 1'b0;
      wait_t(99);
      check_disp("d0_4", 4'b1110, 7'b0011001);
      wait_t(107);
      check_disp("d1_3", 4'b1101, 7'b0110000);
      wait_t(115);
      check_disp("d2_2", 4'b1011, 7'b0100100);
      wait_t(123);
      check_disp("d3_1b", 4'b0111, 7'b1111001);

      wait_t(127);
      check("tick_at_wrap", 32'(frame_tick), 32'd1);
      load = 1'b1; data_in = 16'h1A8F;
      @(negedge clk);
      load = 1'b0;
      check("ready_wrap_load", 32'(ready), 32'd0);
      wait_t(131);
      check_disp("d0_still_4", 4'b1110, 7'b0011001);
      wait_t(179);
      check_disp("d2_A", 4'b1011, 7'b0001000);

      rst = 1'b1;
      @(negedge clk);
      check_disp("midrst", 4'b1111, 7'b1111111);
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_idx", 32'(digit_idx), 32'd0);
      rst = 1'b0;
      wait_t(3);
      check_disp("rst_d0_0", 4'b1110, 7'b1000000);

      load = 1'b1; data_in = 16'h0005;
      @(negedge clk);
      load = 1'b0;
      wait_t(35);
      check_disp("d0_5", 4'b1110, 7'b0010010);
      wait_t(43);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      check_disp("d1_lzb", 4'b1111, 7'b1111111);
      wait_t(59);
      check_disp("d3_lzb", 4'b1111, 7'b1111111);
`else
      check_disp("d1_zero", 4'b1101, 7'b1000000);
      wait_t(59);
      check_disp("d3_zero", 4'b0111, 7'b1000000);
`endif
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
